// File: rtl/pri_decoder_3to8_seq.sv
// Sequenced 3-to-8 decoder: buffers codes in a FIFO and drives each as a
// registered one-hot until acknowledged or timed out, with a zero cycle between selects.
module pri_decoder_3to8_seq #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_code,
    output logic [7:0]               out,
    input  logic                     out_ack,
    output logic                     busy,
    output logic                     timeout_err,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [7:0]  TMAX     = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

    state_t         state, state_nxt;
    logic [2:0]     mem [DEPTH];
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic [AW:0]    count;
    logic [7:0]     timer, timer_nxt;
    logic [7:0]     out_nxt;
    logic           terr_nxt;
    logic           push, pop, full, empty;

    assign full     = (count == FULL_LVL);
    assign empty    = (count == '0);
    assign in_ready = ~full;
    assign push     = in_valid & ~full;
    assign level    = count;
    assign busy     = (state != IDLE) | ~empty;

    // Storage is not reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_code;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            timer       <= '0;
            out         <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            out         <= out_nxt;
            timeout_err <= terr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        out_nxt   = out;
        terr_nxt  = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE, GAP: begin
                out_nxt   = '0;
                state_nxt = IDLE;
                if (!empty) begin
                    pop       = 1'b1;
                    out_nxt   = 8'(1) << mem[rd_ptr];
                    timer_nxt = '0;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                // Ack takes precedence over a coincident timeout.
                if (out_ack) begin
                    out_nxt   = '0;
                    state_nxt = GAP;
                end else if (timer == TMAX) begin
                    out_nxt   = '0;
                    terr_nxt  = 1'b1;
                    state_nxt = GAP;
                end else begin
                    timer_nxt = timer + 8'd1;
                end
            end
            default: begin
                out_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pri_decoder_3to8_seq.sv
// Directed self-checking bench for pri_decoder_3to8_seq (DEPTH=4, TIMEOUT=16).
module tb_pri_decoder_3to8_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_code;
    logic [7:0] out;
    logic       out_ack;
    logic       busy;
    logic       timeout_err;
    logic [2:0] level;

    int checks;
    int failures;

    pri_decoder_3to8_seq #(.DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .out(out), .out_ack(out_ack), .busy(busy),
        .timeout_err(timeout_err), .level(level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_code  = 3'd0;
        out_ack  = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_code  = 3'd0;
        out_ack  = 1'b0;
        repeat (3) tick();
        checks++;
        if (out !== 8'h00) begin failures++; $display("FAIL reset_out got=%h exp=00", out); end
        checks++;
        if (level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        checks++;
        if (busy !== 1'b0 || timeout_err !== 1'b0) begin
            failures++; $display("FAIL reset_busy_terr got=%b%b exp=00", busy, timeout_err);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        in_valid = 1'b1;
        in_code  = 3'd5;
        out_ack  = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out !== 8'h00 || level !== 3'd1 || busy !== 1'b1) begin
            failures++; $display("FAIL single_push out=%h level=%0d busy=%b exp=00/1/1", out, level, busy);
        end
        tick();
        checks++;
        if (out !== 8'h20 || level !== 3'd0) begin
            failures++; $display("FAIL single_drive out=%h level=%0d exp=20/0", out, level);
        end
        tick();
        checks++;
        if (out !== 8'h00 || busy !== 1'b1) begin
            failures++; $display("FAIL single_gap out=%h busy=%b exp=00/1", out, busy);
        end
        tick();
        checks++;
        if (out !== 8'h00 || busy !== 1'b0) begin
            failures++; $display("FAIL single_idle out=%h busy=%b exp=00/0", out, busy);
        end
        out_ack = 1'b0;
    endtask

    task automatic test_order();
        logic [7:0] exp_out [14];
        logic [2:0] codes [4];
        int run;
        exp_out = '{8'h00, 8'h80, 8'h80, 8'h00, 8'h01, 8'h01, 8'h00,
                    8'h08, 8'h08, 8'h00, 8'h08, 8'h08, 8'h00, 8'h00};
        codes = '{3'd7, 3'd0, 3'd3, 3'd3};
        run = 0;
        out_ack = 1'b0;
        for (int i = 0; i < 14; i++) begin
            in_valid = (i < 4);
            in_code  = (i < 4) ? codes[i] : 3'd0;
            tick();
            checks++;
            if (out !== exp_out[i]) begin
                failures++; $display("FAIL order_cycle%0d got=%h exp=%h", i, out, exp_out[i]);
            end
            run     = (out != 8'h00) ? run + 1 : 0;
            out_ack = (run == 2);
        end
        in_valid = 1'b0;
        out_ack  = 1'b0;
    endtask

    task automatic test_full();
        out_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_code  = 3'(i + 1);
            checks++;
            if (in_ready !== 1'b1) begin
                failures++; $display("FAIL full_ready_push%0d got=%b exp=1", i, in_ready);
            end
            tick();
        end
        in_code = 3'd6;
        checks++;
        if (in_ready !== 1'b0 || level !== 3'd4 || out !== 8'h02) begin
            failures++; $display("FAIL full_state ready=%b level=%0d out=%h exp=0/4/02", in_ready, level, out);
        end
        repeat (3) tick();
        checks++;
        if (level !== 3'd4 || in_ready !== 1'b0) begin
            failures++; $display("FAIL full_hold level=%0d ready=%b exp=4/0", level, in_ready);
        end
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        checks++;
        if (out !== 8'h00 || level !== 3'd4 || in_ready !== 1'b0) begin
            failures++; $display("FAIL full_gap out=%h level=%0d ready=%b exp=00/4/0", out, level, in_ready);
        end
        tick();
        checks++;
        if (out !== 8'h04 || level !== 3'd3 || in_ready !== 1'b1) begin
            failures++; $display("FAIL full_pop_refuse out=%h level=%0d ready=%b exp=04/3/1", out, level, in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (level !== 3'd4 || in_ready !== 1'b0) begin
            failures++; $display("FAIL full_late_push level=%0d ready=%b exp=4/0", level, in_ready);
        end
    endtask

    task automatic test_timeout();
        int cnt;
        out_ack  = 1'b0;
        in_valid = 1'b1;
        in_code  = 3'd2;
        tick();
        in_code = 3'd6;
        tick();
        in_valid = 1'b0;
        cnt = (out == 8'h04) ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out != 8'h04) break;
            cnt++;
        end
        checks++;
        if (cnt !== 16) begin failures++; $display("FAIL timeout_len got=%0d exp=16", cnt); end
        checks++;
        if (timeout_err !== 1'b1 || out !== 8'h00) begin
            failures++; $display("FAIL timeout_pulse terr=%b out=%h exp=1/00", timeout_err, out);
        end
        tick();
        checks++;
        if (timeout_err !== 1'b0 || out !== 8'h40) begin
            failures++; $display("FAIL timeout_next terr=%b out=%h exp=0/40", timeout_err, out);
        end
    endtask

    task automatic test_ack_at_timeout();
        int cnt;
        out_ack  = 1'b0;
        in_valid = 1'b1;
        in_code  = 3'd3;
        tick();
        in_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out == 8'h08) cnt++;
            if (cnt == 16 || timeout_err) break;
        end
        checks++;
        if (cnt !== 16 || out !== 8'h08) begin
            failures++; $display("FAIL ackto_reach cnt=%0d out=%h exp=16/08", cnt, out);
        end
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        checks++;
        if (timeout_err !== 1'b0 || out !== 8'h00 || busy !== 1'b1) begin
            failures++; $display("FAIL ackto_gap terr=%b out=%h busy=%b exp=0/00/1", timeout_err, out, busy);
        end
        tick();
        checks++;
        if (timeout_err !== 1'b0 || out !== 8'h00 || busy !== 1'b0) begin
            failures++; $display("FAIL ackto_idle terr=%b out=%h busy=%b exp=0/00/0", timeout_err, out, busy);
        end
    endtask

    task automatic test_ack_ignored();
        out_ack = 1'b1;
        repeat (3) tick();
        checks++;
        if (out !== 8'h00 || busy !== 1'b0 || level !== 3'd0 || timeout_err !== 1'b0) begin
            failures++; $display("FAIL ack_idle out=%h busy=%b level=%0d exp=00/0/0", out, busy, level);
        end
        out_ack = 1'b0;
    endtask

    task automatic test_async_reset();
        out_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_code  = 3'(i + 1);
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (out !== 8'h02 || level !== 3'd3) begin
            failures++; $display("FAIL areset_pre out=%h level=%0d exp=02/3", out, level);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out !== 8'h00 || level !== 3'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL areset_now out=%h level=%0d ready=%b busy=%b exp=00/0/1/0",
                                 out, level, in_ready, busy);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (out !== 8'h00 || busy !== 1'b0) begin
                failures++; $display("FAIL areset_stale%0d out=%h busy=%b exp=00/0", i, out, busy);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        do_reset();
        test_order();
        do_reset();
        test_full();
        do_reset();
        test_timeout();
        do_reset();
        test_ack_at_timeout();
        test_ack_ignored();
        do_reset();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
